icache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and `mem_ctrl`. It answers fetch requests from a valid-tagged array with one-cycle hit latency. On a miss it drives `inst_needed`/`inst_addr` to `mem_ctrl`, waits for `inst_rdy`, fills the line, and returns the word to fetch. A jump abandons any outstanding miss without filling.

---
 rtl/icache.sv | 106 ++++++++++
 tb/tb_icache.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and mem_ctrl: one-word lines,
// single-cycle hits, one outstanding miss that a jump can abandon without filling.
//
// state | meaning
// IDLE  | serve lookups; a hit returns the word on the next edge
// MISS  | inst_needed held to mem_ctrl, waiting for inst_rdy to fill the line
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_LEN   = 32,
    parameter int INST_LEN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_jump,
    input  logic                if_needed,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic                if_rdy,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_busy,
    output logic                inst_needed,
    output logic [ADDR_LEN-1:0] inst_addr,
    input  logic [INST_LEN-1:0] inst_data,
    input  logic                inst_rdy
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [INST_LEN-1:0]   data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_en;

    // byte-offset bits of both addresses carry no information
    wire unused_addr_bits = &{1'b0, if_addr[1:0], inst_addr[1:0], 1'b0};

    assign req_index  = if_addr[INDEX_BITS+1:2];
    assign req_tag    = if_addr[ADDR_LEN-1:INDEX_BITS+2];
    assign fill_index = inst_addr[INDEX_BITS+1:2];
    assign fill_tag   = inst_addr[ADDR_LEN-1:INDEX_BITS+2];
    assign hit        = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign fill_en    = (state == MISS) && inst_rdy && !is_jump;

    // Data and tag storage is left unreset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_index] <= inst_data;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            if_rdy      <= 1'b0;
            if_inst     <= '0;
            if_busy     <= 1'b0;
            inst_needed <= 1'b0;
            inst_addr   <= '0;
        end else begin
            if_rdy <= 1'b0;
            if (is_jump) begin
                // jump wins over a same-cycle return or lookup
                state       <= IDLE;
                inst_needed <= 1'b0;
                if_busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (if_needed) begin
                            if (hit) begin
                                if_rdy  <= 1'b1;
                                if_inst <= data_mem[req_index];
                            end else begin
                                inst_addr   <= {if_addr[ADDR_LEN-1:2], 2'b00};
                                inst_needed <= 1'b1;
                                if_busy     <= 1'b1;
                                state       <= MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (inst_rdy) begin
                            valid[fill_index] <= 1'b1;
                            if_inst           <= inst_data;
                            if_rdy            <= 1'b1;
                            inst_needed       <= 1'b0;
                            if_busy           <= 1'b0;
                            state             <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflicts, jump aborts and async reset.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_jump = 1'b0;
    logic        if_needed = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_rdy;
    logic [31:0] if_inst;
    logic        if_busy;
    logic        inst_needed;
    logic [31:0] inst_addr;
    logic [31:0] inst_data = '0;
    logic        inst_rdy = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    icache dut (
        .clk         (clk),
        .rst         (rst),
        .is_jump     (is_jump),
        .if_needed   (if_needed),
        .if_addr     (if_addr),
        .if_rdy      (if_rdy),
        .if_inst     (if_inst),
        .if_busy     (if_busy),
        .inst_needed (inst_needed),
        .inst_addr   (inst_addr),
        .inst_data   (inst_data),
        .inst_rdy    (inst_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, ".if_rdy"}, {31'b0, if_rdy}, 32'd0);
        chk({tag, ".inst_needed"}, {31'b0, inst_needed}, 32'd0);
        chk({tag, ".if_busy"}, {31'b0, if_busy}, 32'd0);
    endtask

    // request addr, expect a miss, return data after lat cycles, expect the fill
    task automatic miss_fill(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input int lat);
        if_needed = 1'b1;
        if_addr   = addr;
        step();
        chk({tag, ".miss_req"}, {31'b0, inst_needed}, 32'd1);
        chk({tag, ".miss_addr"}, inst_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".busy"}, {31'b0, if_busy}, 32'd1);
        chk({tag, ".no_rdy"}, {31'b0, if_rdy}, 32'd0);
        repeat (lat - 1) step();
        chk({tag, ".held_req"}, {31'b0, inst_needed}, 32'd1);
        inst_rdy  = 1'b1;
        inst_data = data;
        step();
        inst_rdy  = 1'b0;
        if_needed = 1'b0;
        chk({tag, ".fill_rdy"}, {31'b0, if_rdy}, 32'd1);
        chk({tag, ".fill_inst"}, if_inst, data);
        chk({tag, ".fill_req_drop"}, {31'b0, inst_needed}, 32'd0);
        chk({tag, ".fill_busy_drop"}, {31'b0, if_busy}, 32'd0);
        step();
        chk({tag, ".rdy_pulse"}, {31'b0, if_rdy}, 32'd0);
    endtask

    task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
        if_needed = 1'b1;
        if_addr   = addr;
        step();
        if_needed = 1'b0;
        chk({tag, ".hit_rdy"}, {31'b0, if_rdy}, 32'd1);
        chk({tag, ".hit_inst"}, if_inst, data);
        chk({tag, ".hit_no_req"}, {31'b0, inst_needed}, 32'd0);
        step();
        chk({tag, ".hit_pulse"}, {31'b0, if_rdy}, 32'd0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #2;
        check_idle_outs("reset");
        chk("reset.if_inst", if_inst, 32'd0);
        chk("reset.inst_addr", inst_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // cold miss then hit
        miss_fill("cold", 32'h0000_1004, 32'h00A0_0093, 5);
        hit("hit1004", 32'h0000_1004, 32'h00A0_0093);

        // 0x1000 misses; 0x1004 presented during the miss only hits afterwards
        if_needed = 1'b1;
        if_addr   = 32'h0000_1000;
        step();
        chk("seq.miss_req", {31'b0, inst_needed}, 32'd1);
        chk("seq.miss_addr", inst_addr, 32'h0000_1000);
        if_addr = 32'h0000_1004;
        step();
        step();
        chk("seq.addr_held", inst_addr, 32'h0000_1000);
        chk("seq.no_rdy", {31'b0, if_rdy}, 32'd0);
        inst_rdy  = 1'b1;
        inst_data = 32'h0000_0013;
        step();
        inst_rdy = 1'b0;
        chk("seq.fill_rdy", {31'b0, if_rdy}, 32'd1);
        chk("seq.fill_inst", if_inst, 32'h0000_0013);
        step();
        if_needed = 1'b0;
        chk("seq.hit_rdy", {31'b0, if_rdy}, 32'd1);
        chk("seq.hit_inst", if_inst, 32'h00A0_0093);
        chk("seq.hit_no_req", {31'b0, inst_needed}, 32'd0);
        step();
        hit("hit1000", 32'h0000_1000, 32'h0000_0013);

        // conflict on index 4: tag 0 vs tag 1
        miss_fill("conf_a", 32'h0000_0010, 32'h1111_1111, 5);
        miss_fill("conf_b", 32'h0000_0210, 32'h2222_2222, 5);
        miss_fill("conf_a2", 32'h0000_0010, 32'h1111_1111, 3);
        miss_fill("conf_b2", 32'h0000_0210, 32'h2222_2222, 2);

        // jump aborts a miss two cycles in; the late return is ignored
        if_needed = 1'b1;
        if_addr   = 32'h0000_2000;
        step();
        chk("jmp.miss_req", {31'b0, inst_needed}, 32'd1);
        if_needed = 1'b0;
        step();
        is_jump = 1'b1;
        step();
        is_jump = 1'b0;
        check_idle_outs("jmp.abort");
        inst_rdy  = 1'b1;
        inst_data = 32'hDEAD_BEEF;
        step();
        inst_rdy = 1'b0;
        chk("jmp.late_rdy", {31'b0, if_rdy}, 32'd0);
        miss_fill("jmp.remiss", 32'h0000_2000, 32'h0000_2222, 4);

        // jump in the same cycle as the return: no fill, no pulse
        if_needed = 1'b1;
        if_addr   = 32'h0000_3000;
        step();
        chk("coll.miss_req", {31'b0, inst_needed}, 32'd1);
        if_needed = 1'b0;
        step();
        is_jump   = 1'b1;
        inst_rdy  = 1'b1;
        inst_data = 32'h4444_4444;
        step();
        is_jump  = 1'b0;
        inst_rdy = 1'b0;
        check_idle_outs("coll");
        miss_fill("coll.remiss", 32'h0000_3000, 32'h5555_5555, 2);

        // jump alongside a lookup drops the hit
        is_jump   = 1'b1;
        if_needed = 1'b1;
        if_addr   = 32'h0000_1004;
        step();
        is_jump   = 1'b0;
        if_needed = 1'b0;
        check_idle_outs("jmp_lookup");

        // async reset mid-miss
        if_needed = 1'b1;
        if_addr   = 32'h0000_4000;
        step();
        if_needed = 1'b0;
        chk("arst.miss_req", {31'b0, inst_needed}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outs("arst");
        chk("arst.if_inst", if_inst, 32'd0);
        chk("arst.inst_addr", inst_addr, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        inst_rdy  = 1'b1;
        inst_data = 32'h6666_6666;
        step();
        inst_rdy = 1'b0;
        chk("arst.late_rdy", {31'b0, if_rdy}, 32'd0);
        miss_fill("arst.cold1004", 32'h0000_1004, 32'h7777_7777, 1);
        miss_fill("arst.cold0010", 32'h0000_0010, 32'h8888_8888, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
